instr_fetch: RTL and testbench

Instruction fetch stage for the MIPS datapath. It holds the program counter, issues word reads to instruction memory with one request outstanding, and presents each fetched instruction with its PC and opcode field to the decode stage. `if_opcode` drives the control decoder's `opcode` input. The stage supports downstream stall, taken-branch redirect/flush and variable memory latency.

---
 rtl/instr_fetch.sv | 150 +++++++++++++++
 tb/tb_instr_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in
// flight and hands fetched words (with their PC) to decode, honouring stall and branch flush.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [5:0]  if_opcode
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_q, buf_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;

  logic [31:0] redirect_pc;
  logic [31:0] pc_inc;
  logic        slot_free;

  assign redirect_pc = branch_target & ~32'h0000_0003;
  assign pc_inc      = pc_q + 32'd4;
  assign slot_free   = !valid_q || !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      buf_q   <= 32'h0;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      ifpc_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;

    // Decode takes the current word on any unstalled edge; a load below re-raises valid.
    if (valid_q && !stall) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (branch_taken) begin
          pc_d = redirect_pc;
        end
      end

      S_FETCH: begin
        state_d = S_WAIT;
        // The request issued this cycle still targets the old path, so its data must be dropped.
        if (branch_taken) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (!imem_rvalid) begin
          if (branch_taken) begin
            pc_d   = redirect_pc;
            kill_d = 1'b1;
          end
        end else if (kill_q || branch_taken) begin
          kill_d  = 1'b0;
          state_d = S_FETCH;
          if (branch_taken) begin
            pc_d = redirect_pc;
          end
        end else if (slot_free) begin
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          buf_d   = imem_rdata;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d = buf_q;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush wins over stall and over any word loaded on the same edge.
    if (branch_taken) begin
      valid_d = 1'b0;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign if_opcode = instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized stall/branch/latency traffic
// scored against an address-stream model of the fetch stage.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_rvalid, stall, branch_taken, if_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, if_instr, if_pc;
  logic [5:0]  if_opcode;

  logic        w_imem_req, w_imem_rvalid, w_stall, w_branch_taken, w_if_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_branch_target, w_if_instr, w_if_pc;
  logic [5:0]  w_if_opcode;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
    .stall(w_stall), .branch_taken(w_branch_taken), .branch_target(w_branch_target),
    .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_opcode(w_if_opcode)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  bit          pend, w_pend, rand_lat;
  logic [31:0] pend_addr, w_pend_addr, exp_pc;
  int          pend_due, lat, n_consumed;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C01_0004;
      32'h0000_0004: return 32'hAC01_0008;
      32'h0000_0008: return 32'h1022_0002;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock cycle: at the negedge, play memory, apply stimulus and score consumption.
  task automatic step(input bit st, input bit br, input logic [31:0] tgt);
    logic [31:0] wexp;
    int          l;
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pend && cyc == pend_due) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      pend        = 1'b0;
    end
    if (imem_req) begin
      check("one_outstanding", 32'(pend), 32'h0);
      check("addr_align", 32'(imem_addr[1:0]), 32'h0);
      l         = rand_lat ? int'($urandom_range(1, 4)) : lat;
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_due  = cyc + l;
    end
    w_imem_rvalid = w_pend;
    w_imem_rdata  = mem_word(w_pend_addr);
    w_pend        = w_imem_req;
    w_pend_addr   = w_imem_addr;

    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    if (if_valid && !st && !br) begin
      wexp = mem_word(exp_pc);
      check("cons_pc", if_pc, exp_pc);
      check("cons_instr", if_instr, wexp);
      check("cons_opcode", 32'(if_opcode), 32'(wexp[31:26]));
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    if (br) exp_pc = tgt & ~32'h3;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    pend          = 1'b0;
    w_pend        = 1'b0;
    imem_rvalid   = 1'b0;
    w_imem_rvalid = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    #1;
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_opcode", 32'(if_opcode), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    cyc         = 0;
    exp_pc      = 32'h0;
    // Stale response landing in IDLE must be ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    check("idle_req", 32'(imem_req), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int start_cons;
    bit st, br;
    logic [31:0] tgt;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    w_stall = 1'b0; w_branch_taken = 1'b0; w_branch_target = 32'h0;
    w_imem_rvalid = 1'b0; w_imem_rdata = 32'h0;
    lat = 1; rand_lat = 1'b0; pend = 1'b0; w_pend = 1'b0; n_consumed = 0; cyc = 0;
    exp_pc = 32'h0;
    @(negedge clk);
    do_reset();

    // Straight line, 1-cycle memory; wrap instance runs alongside
    step(0, 0, 0);
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("w_first_addr", w_imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    check("sl_gap0", 32'(if_valid), 32'h0);
    step(0, 0, 0);
    check("sl_v0", 32'(if_valid), 32'h1);
    check("sl_pc0", if_pc, 32'h0);
    check("sl_op0", 32'(if_opcode), 32'h23);
    check("w_pc0", w_if_pc, 32'hFFFF_FFFC);
    check("w_v0", 32'(w_if_valid), 32'h1);
    step(0, 0, 0);
    check("sl_gap1", 32'(if_valid), 32'h0);
    step(0, 0, 0);
    check("sl_pc1", if_pc, 32'h4);
    check("sl_op1", 32'(if_opcode), 32'h2B);
    check("w_pc1", w_if_pc, 32'h0);
    check("w_instr1", w_if_instr, 32'h8C01_0004);
    step(0, 0, 0);
    step(1, 0, 0);
    check("sl_v2", 32'(if_valid), 32'h1);
    check("sl_pc2", if_pc, 32'h8);
    check("sl_op2", 32'(if_opcode), 32'h04);
    step(1, 0, 0);
    check("wait_v", 32'(if_valid), 32'h1);
    check("wait_req", 32'(imem_req), 32'h0);
    do_reset();

    // Stall: word at 8 parks in HOLD while 4 is held
    repeat (4) step(0, 0, 0);
    step(1, 0, 0);
    check("st_pc4", if_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      check("st_noreq", 32'(imem_req), 32'h0);
      check("st_hold_pc", if_pc, 32'h4);
    end
    step(0, 0, 0);
    check("st_rel_pc", if_pc, 32'h4);
    lat = 3;
    step(0, 0, 0);
    check("st_next_pc", if_pc, 32'h8);
    check("st_next_v", 32'(if_valid), 32'h1);
    check("st_next_addr", imem_addr, 32'hC);

    // Branch in WAIT with 3-cycle latency
    repeat (4) step(0, 0, 0);
    check("bw_req_addr", imem_addr, 32'h10);
    step(0, 1, 32'h40);
    check("bw_v_br", 32'(if_valid), 32'h0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("bw_v_kill", 32'(if_valid), 32'h0);
    step(0, 0, 0);
    check("bw_req", 32'(imem_req), 32'h1);
    check("bw_addr", imem_addr, 32'h40);
    check("bw_v_fetch", 32'(if_valid), 32'h0);
    repeat (3) step(0, 0, 0);
    check("bw_v_pre", 32'(if_valid), 32'h0);
    step(1, 0, 0);
    check("bw_pc40", if_pc, 32'h40);

    // Branch in HOLD while stalled, unaligned target
    repeat (3) step(1, 0, 0);
    step(1, 1, 32'h103);
    check("bh_v_pre", 32'(if_valid), 32'h1);
    check("bh_noreq", 32'(imem_req), 32'h0);
    step(0, 0, 0);
    check("bh_v_flush", 32'(if_valid), 32'h0);
    check("bh_addr", imem_addr, 32'h100);
    repeat (4) step(0, 0, 0);
    check("bh_pc", if_pc, 32'h100);

    // Randomized stall / branch / latency traffic
    rand_lat   = 1'b1;
    start_cons = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      br  = ($urandom_range(0, 99) < 4);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step(st, br, tgt);
    end
    repeat (12) step(0, 0, 0);
    check("progress", 32'((n_consumed - start_cons) > 100), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
